serial_link_tx: RTL and testbench

- Per-output-channel transmitter that sits directly downstream of the router's routing/arbitration stage.
- Consumes one flit per `ena` pulse on the channel's item bus and serialises it onto a narrow inter-router link, LANES bits per cycle, LSB first.
- Drives the `busy` back-pressure that the arbiter samples.
- Tracks credits returned by the far-end rx buffer, so it never sends a flit the neighbour cannot store.

---
 rtl/serial_link_tx_pkg.sv | 24 ++
 rtl/serial_link_tx_credit_counter.sv | 48 ++++
 rtl/serial_link_tx.sv | 151 +++++++++++++++
 tb/tb_serial_link_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_tx_pkg.sv
// Shared definitions for the serial link transmitter and its credit counter.
// The TX_PARITY state exists only when SERIAL_LINK_PARITY_EN is defined.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

package serial_link_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
`ifdef SERIAL_LINK_PARITY_EN
    TX_PARITY = 2'd2,
`endif
    TX_SHIFT  = 2'd1
  } tx_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/serial_link_tx_credit_counter.sv
// Credit counter for a far-end buffer of CREDITS slots; saturates at CREDITS and
// flags returns that would overflow. Intended for reuse on the rx credit-return side.
module credit_counter
  import serial_link_tx_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  input  logic ret,
  output logic zero,
  output logic overflow
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A simultaneous consume and return cancel out; zero looks ahead to the next count
  // so the owner can register back-pressure in the same cycle the count changes.
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (ret && !consume) begin
      if (count_q == MAX_CNT) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (consume && !ret && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign zero = (count_d == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= MAX_CNT;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_link_tx.sv
// Credit-based flit serialiser: one flit per ena, LANES bits per beat, LSB first.
// Define SERIAL_LINK_PARITY_EN to append a one-beat even-parity trailer to each flit.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module serial_link_tx
  import serial_link_tx_pkg::*;
#(
  parameter int DATA_W  = `PAYLOAD_SIZE + `ADDR_BITS,
  parameter int LANES   = 1,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] item_in,
  input  logic              ena,
  output logic              busy,
  output logic [LANES-1:0]  ser_data,
  output logic              ser_valid,
  output logic              ser_last,
  input  logic              credit_in,
  output logic              err
);

  localparam int BEATS  = ceil_div(DATA_W, LANES);
  localparam int SH_W   = BEATS * LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  tx_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [LANES-1:0]  ser_data_d;
  logic              ser_valid_d;
  logic              ser_last_d;
  logic              capture;
  logic              credit_zero;
  logic              credit_overflow;
`ifdef SERIAL_LINK_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign capture = (state_q == TX_IDLE) && ena && !busy;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .clk      (clk),
    .reset    (reset),
    .consume  (capture),
    .ret      (credit_in),
    .zero     (credit_zero),
    .overflow (credit_overflow)
  );

  // Output registers are loaded with the beat for the coming cycle, so the first
  // beat is already on the link the cycle after capture.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    shreg_d     = shreg_q;
    ser_data_d  = '0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (capture) begin
          state_d     = TX_SHIFT;
          beat_d      = '0;
          shreg_d     = SH_W'(item_in) >> LANES;
          ser_data_d  = item_in[LANES-1:0];
          ser_valid_d = 1'b1;
`ifdef SERIAL_LINK_PARITY_EN
          parity_d    = ^item_in;
`else
          ser_last_d  = (BEATS == 1);
`endif
        end
      end
      TX_SHIFT: begin
        if (beat_q == LAST_BEAT) begin
`ifdef SERIAL_LINK_PARITY_EN
          state_d     = TX_PARITY;
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b1;
          ser_data_d  = LANES'(parity_q);
`else
          state_d     = TX_IDLE;
`endif
        end else begin
          beat_d      = beat_q + BEAT_W'(1);
          ser_data_d  = shreg_q[LANES-1:0];
          shreg_d     = shreg_q >> LANES;
          ser_valid_d = 1'b1;
`ifndef SERIAL_LINK_PARITY_EN
          ser_last_d  = (beat_d == LAST_BEAT);
`endif
        end
      end
`ifdef SERIAL_LINK_PARITY_EN
      TX_PARITY: begin
        state_d = TX_IDLE;
      end
`endif
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // busy is low in the capture cycle itself; the router has already read its FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      beat_q    <= '0;
      shreg_q   <= '0;
      ser_data  <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shreg_q   <= shreg_d;
      ser_data  <= ser_data_d;
      ser_valid <= ser_valid_d;
      ser_last  <= ser_last_d;
      busy      <= (state_d != TX_IDLE) || credit_zero;
      err       <= err || (ena && busy) || credit_overflow;
    end
  end

`ifdef SERIAL_LINK_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_serial_link_tx.sv
// Scoreboard bench for serial_link_tx (DATA_W=12, LANES=4, CREDITS=2); honours
// SERIAL_LINK_PARITY_EN when the design is built with it.
module tb_serial_link_tx;

  localparam int DATA_W  = 12;
  localparam int LANES   = 4;
  localparam int CREDITS = 2;
  localparam int BEATS   = (DATA_W + LANES - 1) / LANES;
`ifdef SERIAL_LINK_PARITY_EN
  localparam int TX_CYCLES = BEATS + 1;
`else
  localparam int TX_CYCLES = BEATS;
`endif

  typedef struct {
    logic [LANES-1:0] data;
    bit               last;
    int               cyc;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] item_in = '0;
  logic              ena = 1'b0;
  logic              busy;
  logic [LANES-1:0]  ser_data;
  logic              ser_valid;
  logic              ser_last;
  logic              credit_in = 1'b0;
  logic              err;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  beat_t exp_q[$];

  int m_credits = CREDITS;
  int m_tx = 0;
  bit m_busy = 1'b0;
  bit m_err = 1'b0;

  serial_link_tx #(
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .CREDITS (CREDITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .item_in   (item_in),
    .ena       (ena),
    .busy      (busy),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .credit_in (credit_in),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected link traffic for one flit: nibbles LSB first, optional parity trailer.
  task automatic push_flit(input logic [DATA_W-1:0] it, input int first_cyc);
    beat_t b;
    for (int i = 0; i < BEATS; i++) begin
      b.data = LANES'((it >> (LANES * i)) & ((1 << LANES) - 1));
`ifdef SERIAL_LINK_PARITY_EN
      b.last = 1'b0;
`else
      b.last = (i == BEATS - 1);
`endif
      b.cyc  = first_cyc + i;
      exp_q.push_back(b);
    end
`ifdef SERIAL_LINK_PARITY_EN
    b.data = LANES'(^it);
    b.last = 1'b1;
    b.cyc  = first_cyc + BEATS;
    exp_q.push_back(b);
`endif
  endtask

  // One clock of stimulus; the model predicts busy/err for the following cycle.
  task automatic apply_stimulus(input bit e, input logic [DATA_W-1:0] it, input bit cr);
    bit cap;
    ena       = e;
    item_in   = it;
    credit_in = cr;
    cap = e && !m_busy;
    if (e && m_busy) m_err = 1'b1;
    if (cap) push_flit(it, cyc + 1);
    if (cr && !cap && m_credits == CREDITS) m_err = 1'b1;
    else m_credits = m_credits + (cr ? 1 : 0) - (cap ? 1 : 0);
    if (cap) m_tx = TX_CYCLES;
    else if (m_tx > 0) m_tx--;
    m_busy = (m_tx > 0) || (m_credits == 0);
    @(posedge clk);
    #1;
    ena       = 1'b0;
    credit_in = 1'b0;
    check_output("busy", busy, m_busy);
    check_output("err", err, m_err);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      apply_stimulus(1'b0, '0, 1'b0);
      n++;
    end
    check_output("idle_timeout", m_busy, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_valid", ser_valid, 1'b0);
    check_output("rst_last", ser_last, 1'b0);
    check_output("rst_data", ser_data, '0);
    check_output("rst_err", err, 1'b0);
    exp_q.delete();
    m_credits = CREDITS;
    m_tx = 0;
    m_busy = 1'b0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every valid beat must match the next expected beat, including its cycle.
  always @(negedge clk) begin
    if (reset && ser_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL unexpected_beat: got data=%0h last=%0b, expected no beat (cycle %0d)", ser_data, ser_last, cyc);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        if (ser_data !== b.data || ser_last !== b.last || cyc != b.cyc) begin
          n_errors++;
          $display("[TB] FAIL beat: got data=%0h last=%0b cycle=%0d, expected data=%0h last=%0b cycle=%0d",
                   ser_data, ser_last, cyc, b.data, b.last, b.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit e;
    bit cr;
    $display("[TB] start, TX_CYCLES=%0d", TX_CYCLES);
    #13;
    do_reset();

    $display("[TB] single flit");
    apply_stimulus(1'b1, 12'hA5C, 1'b0);
    idle(4);
    check_output("pending_single", exp_q.size(), 0);

    $display("[TB] credit exhaustion");
    do_reset();
    apply_stimulus(1'b1, 12'h321, 1'b0);
    wait_idle(20);
    apply_stimulus(1'b1, 12'h654, 1'b0);
    idle(TX_CYCLES + 3);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 12'h987, 1'b0);
    idle(TX_CYCLES + 1);

    $display("[TB] simultaneous capture and credit");
    do_reset();
    apply_stimulus(1'b1, 12'h0F0, 1'b0);
    wait_idle(20);
    apply_stimulus(1'b1, 12'hBEE, 1'b1);
    wait_idle(20);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1);
    idle(2);

    $display("[TB] ena while busy");
    do_reset();
    apply_stimulus(1'b1, 12'h111, 1'b0);
    apply_stimulus(1'b1, 12'hFFF, 1'b0);
    idle(TX_CYCLES + 2);

    $display("[TB] reset mid-flit");
    do_reset();
    apply_stimulus(1'b1, 12'h456, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    do_reset();
    apply_stimulus(1'b1, 12'h123, 1'b0);
    wait_idle(20);
    apply_stimulus(1'b1, 12'h007, 1'b0);
    idle(TX_CYCLES + 2);

    $display("[TB] random traffic");
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e  = m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
      cr = (m_credits < CREDITS) && ($urandom_range(0, 2) == 0);
      apply_stimulus(e, DATA_W'($urandom), cr);
    end
    for (int i = 0; i < CREDITS; i++) begin
      if (m_credits < CREDITS) apply_stimulus(1'b0, '0, 1'b1);
    end
    idle(TX_CYCLES + 2);
    check_output("pending_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
